axis_rr_arbiter: RTL
====================

# axis_rr_arbiter

Round-robin arbiter that shares one AXI-Stream sink, typically the write side of an `axis_fifo`, between `NUM_SRC` independent stream sources. Grants one source at a time for a bounded burst of beats. Forwards that source's beats through a single registered output stage. Rotates priority so that no continuously requesting source starves.

## Interface
Parameters:
- `NUM_SRC`, 4: number of source streams; ≥2.
- `AXI_DATA_WIDTH`, 32: tdata width.
- `BURST_LEN`, 8: maximum beats per grant; ≥1.

Ports:
- `aclk`  in  1  clock.
- `aresetn`  in  1  reset, asynchronous, active-low.
- `s_tdata`  in  `NUM_SRC*AXI_DATA_WIDTH`  source data; source i occupies bits [i*W +: W].
- `s_tvalid`  in  `NUM_SRC`  per-source valid.
- `s_tready`  out  `NUM_SRC`  per-source ready; at most one bit high.
- `m_axis`  `axis_if.m_axis`  `AXI_DATA_WIDTH`  arbitrated output; tdata/tvalid are registered.
- `grant`  out  `NUM_SRC`  one-hot current grant; all zero when idle.
- `grant_id`  out  `$clog2(NUM_SRC)`  index of the last or current grant.
- `busy`  out  1  high while in ARB_GRANT.

## Operation
- State machine with two states:
  - ARB_IDLE:
    - If any `s_tvalid` bit is set, pick the first requesting index after `grant_id`, scanning upward and wrapping modulo `NUM_SRC`.
    - Register `grant` and `grant_id`, clear `beat_cnt`, go to ARB_GRANT.
    - Otherwise stay in ARB_IDLE.
  - ARB_GRANT, granted index g:
    - `s_tready[g]` = `!m_axis.tvalid || m_axis.tready`.
    - Accept when `s_tvalid[g] && s_tready[g]`: load `m_axis.tdata` with source g's data, set `m_axis.tvalid`, increment `beat_cnt`.
    - Release to ARB_IDLE and clear `grant` when either:
      - the accepted beat is the `BURST_LEN`-th, or
      - `s_tready[g]` is high and `s_tvalid[g]` is low (source paused).
    - When `s_tready[g]` is low (downstream stall), hold the state regardless of `s_tvalid[g]`.
- Output register rules:
  - `m_axis.tvalid` clears on `m_axis.tready` when no new beat loads in the same cycle.
  - `m_axis.tdata` holds its value while `tvalid && !tready`.
  - The output drains independently of the arbiter state. A beat pending at release is still delivered.
- `beat_cnt` is `$clog2(BURST_LEN+1)` bits wide and never exceeds `BURST_LEN`.
- Ungranted sources see `s_tready` = 0.
- Sources must hold tvalid/tdata stable until accepted.

## Timing
- Reset values (asynchronous, immediate):
  - State ARB_IDLE.
  - `grant` = 0, `grant_id` = `NUM_SRC-1`, so source 0 wins first.
  - `busy` = 0, `s_tready` = 0.
  - `m_axis.tvalid` = 0, `m_axis.tdata` = 0.
  - `beat_cnt` = 0.
- Reset mid-burst discards the beat held in the output register. No partial state survives.
- Latency:
  - Request seen in ARB_IDLE at cycle n gives `grant`/`s_tready` at n+1.
  - First beat accepted at n+1 appears on `m_axis` at n+2.
- Throughput: one beat per cycle within a burst while the downstream is ready.
- Every grant change costs exactly one ARB_IDLE bubble cycle.
- Simultaneous load and drain in one cycle (output register full, `m_axis.tready` high, new accept): `tvalid` stays 1 and `tdata` is replaced.
- Single requester: it is re-granted after each bubble.
- `BURST_LEN` = 1: every beat is followed by an arbitration cycle.
- `grant_id` wrap: after granting index `NUM_SRC-1`, the scan resumes at index 0.

## Structure
- Package `axis_arb_pkg` holds:
  - `arb_state_t` enum (ARB_IDLE, ARB_GRANT).
  - Function `rr_next(req, last)` returning the next index in round-robin order.
- Sub-module `axis_rr_pick`: purely combinational. Inputs are the request vector and `grant_id`; outputs are the one-hot next grant, its index and a `found` flag.
- Top level contains the FSM, the beat counter and the output register.
- An instance typically drives the `s_axis` port of `axis_fifo`.

## Test plan
- Reset then all four sources valid, `BURST_LEN`=8, `m_axis.tready`=1 → grants go 0,1,2,3,0. Each grant yields 8 consecutive beats, separated by one idle cycle; 32 output beats in order.
- Only source 2 valid with 3 beats then drops tvalid → grant 2, 3 beats out, release on the pause cycle. `busy` falls one cycle after the last accept.
- Downstream stall: `m_axis.tready`=0 for 5 cycles mid-burst → `s_tready` low, `m_axis.tdata` stable, `beat_cnt` frozen. Burst resumes with no loss or duplication.
- Back-to-back load/drain at full rate with data values 0x1..0x10 → output sequence identical, with no gaps inside a burst.
- `aresetn` asserted asynchronously mid-burst with `m_axis.tvalid`=1 → outputs zero before the next clock edge. After release, source 0 is granted first.
- Fairness: sources 1 and 3 hold tvalid for 1000 cycles → grant counts differ by ≤1. `s_tready` is never multi-hot (assertion).

Source files
------------

// File: rtl/axis_arb_pkg.sv
// Shared types and the round-robin search helper for the AXI-Stream arbiter.
package axis_arb_pkg;

    typedef enum logic [0:0] {
        ARB_IDLE,
        ARB_GRANT
    } arb_state_t;

    // Widest request vector rr_next can scan; callers zero-pad narrower vectors.
    localparam int unsigned MaxSrc = 32;

    // First requesting index strictly after 'last', wrapping modulo 'num'.
    // Returns 'last' when nothing requests.
    function automatic int unsigned rr_next(input logic [MaxSrc-1:0] req,
                                            input int unsigned       num,
                                            input int unsigned       last);
        int unsigned idx;
        int unsigned pick;
        pick = last;
        // Walk from the farthest candidate down so the nearest one wins.
        for (int unsigned k = MaxSrc; k >= 1; k--) begin
            idx = last + k;
            if (idx >= num) begin
                idx = idx - num;
            end
            if ((k <= num) && (idx < MaxSrc) && req[idx[4:0]]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/axis_if.sv
// AXI-Stream bundle (data, valid, ready) with master and slave views.
interface axis_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport m_axis (output tdata, output tvalid, input tready);
    modport s_axis (input tdata, input tvalid, output tready);
endinterface

// File: rtl/axis_rr_pick.sv
// Combinational round-robin pick: next requester after the last grant.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req_i,
    input  logic [$clog2(NUM_SRC)-1:0] last_id_i,
    output logic [NUM_SRC-1:0]         next_grant_o,
    output logic [$clog2(NUM_SRC)-1:0] next_id_o,
    output logic                       found_o
);
    localparam int unsigned IdW = $clog2(NUM_SRC);

    logic [MaxSrc-1:0] req_ext;
    int unsigned       pick;

    // Search the padded request vector and build the one-hot grant.
    always_comb begin
        req_ext                = '0;
        req_ext[NUM_SRC-1:0]   = req_i;
        pick                   = rr_next(req_ext, NUM_SRC, int'(last_id_i));
        found_o                = |req_i;
        next_id_o              = pick[IdW-1:0];
        next_grant_o           = '0;
        if (found_o) begin
            next_grant_o[next_id_o] = 1'b1;
        end
    end
endmodule

// File: rtl/axis_rr_arbiter.sv
// Round-robin arbiter merging NUM_SRC AXI-Stream sources into one registered
// output stage, granting each source up to BURST_LEN beats at a time.
module axis_rr_arbiter
    import axis_arb_pkg::*;
#(
    parameter int unsigned NUM_SRC        = 4,
    parameter int unsigned AXI_DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN      = 8
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic [NUM_SRC*AXI_DATA_WIDTH-1:0]   s_tdata,
    input  logic [NUM_SRC-1:0]                  s_tvalid,
    output logic [NUM_SRC-1:0]                  s_tready,
    axis_if.m_axis                              m_axis,
    output logic [NUM_SRC-1:0]                  grant,
    output logic [$clog2(NUM_SRC)-1:0]          grant_id,
    output logic                                busy
);
    localparam int unsigned IdW  = $clog2(NUM_SRC);
    localparam int unsigned CntW = $clog2(BURST_LEN + 1);
    localparam int unsigned W    = AXI_DATA_WIDTH;

    arb_state_t          state_q, state_d;
    logic [NUM_SRC-1:0]  grant_q, grant_d;
    logic [IdW-1:0]      gid_q, gid_d;
    logic [CntW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [W-1:0]        tdata_q, tdata_d;
    logic                tvalid_q, tvalid_d;

    logic [NUM_SRC-1:0]  pick_grant;
    logic [IdW-1:0]      pick_id;
    logic                pick_found;

    logic                out_ready;
    logic                src_valid;
    logic                accept;
    logic                last_beat;
    logic [W-1:0]        src_data;

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC)
    ) u_pick (
        .req_i        (s_tvalid),
        .last_id_i    (gid_q),
        .next_grant_o (pick_grant),
        .next_id_o    (pick_id),
        .found_o      (pick_found)
    );

    // Handshake terms for the currently granted source.
    always_comb begin
        out_ready = !tvalid_q || m_axis.tready;
        src_valid = s_tvalid[gid_q];
        src_data  = s_tdata[gid_q*W +: W];
        accept    = (state_q == ARB_GRANT) && src_valid && out_ready;
        last_beat = (beat_cnt_q == CntW'(BURST_LEN - 1));
    end

    // Next-state for the arbiter FSM, beat counter and output register.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gid_d      = gid_q;
        beat_cnt_d = beat_cnt_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        s_tready   = '0;

        // Output stage drains on its own, independent of the grant.
        if (accept) begin
            tdata_d  = src_data;
            tvalid_d = 1'b1;
        end else if (m_axis.tready) begin
            tvalid_d = 1'b0;
        end

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_grant;
                    gid_d      = pick_id;
                    beat_cnt_d = '0;
                    state_d    = ARB_GRANT;
                end
            end
            ARB_GRANT: begin
                s_tready = grant_q & {NUM_SRC{out_ready}};
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                    if (last_beat) begin
                        grant_d = '0;
                        state_d = ARB_IDLE;
                    end
                end else if (out_ready && !src_valid) begin
                    // Source paused: give the others a turn.
                    grant_d = '0;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State registers; reset points grant_id at the top index so source 0 wins first.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= ARB_IDLE;
            grant_q    <= '0;
            gid_q      <= IdW'(NUM_SRC - 1);
            beat_cnt_q <= '0;
            tdata_q    <= '0;
            tvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gid_q      <= gid_d;
            beat_cnt_q <= beat_cnt_d;
            tdata_q    <= tdata_d;
            tvalid_q   <= tvalid_d;
        end
    end

    assign grant         = grant_q;
    assign grant_id      = gid_q;
    assign busy          = (state_q == ARB_GRANT);
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tvalid = tvalid_q;
endmodule
